axil_ctrl_slave: RTL and testbench

// AXI4-Lite control-register responder for streaming kernels: the slave end of the SoftReg->AXI-Lite

---
 rtl/axil_ctrl_slave.sv | 206 ++++++++++++++++++++
 tb/tb_axil_ctrl_slave.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_ctrl_slave.sv
// AXI4-Lite control slave for streaming kernels: CTRL/GIE/IER/ISR plus NUM_ARGS 64-bit
// argument registers, with the ap_start/ap_done/ap_idle/ap_ready block handshake and interrupt.
module axil_ctrl_slave #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int NUM_ARGS = 4
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     s_axi_control_AWVALID,
  output logic                     s_axi_control_AWREADY,
  input  logic [ADDR_W-1:0]        s_axi_control_AWADDR,
  input  logic                     s_axi_control_WVALID,
  output logic                     s_axi_control_WREADY,
  input  logic [DATA_W-1:0]        s_axi_control_WDATA,
  input  logic [DATA_W/8-1:0]      s_axi_control_WSTRB,
  output logic                     s_axi_control_BVALID,
  input  logic                     s_axi_control_BREADY,
  output logic [1:0]               s_axi_control_BRESP,
  input  logic                     s_axi_control_ARVALID,
  output logic                     s_axi_control_ARREADY,
  input  logic [ADDR_W-1:0]        s_axi_control_ARADDR,
  output logic                     s_axi_control_RVALID,
  input  logic                     s_axi_control_RREADY,
  output logic [DATA_W-1:0]        s_axi_control_RDATA,
  output logic [1:0]               s_axi_control_RRESP,
  output logic                     ap_start,
  input  logic                     ap_done,
  input  logic                     ap_idle,
  input  logic                     ap_ready,
  output logic [64*NUM_ARGS-1:0]   args,
  output logic                     interrupt
);

  localparam logic [4:0] ADDR_CTRL = 5'd0;
  localparam logic [4:0] ADDR_GIE  = 5'd1;
  localparam logic [4:0] ADDR_IER  = 5'd2;
  localparam logic [4:0] ADDR_ISR  = 5'd3;
  localparam logic [4:0] ADDR_ARG0 = 5'd4;

  typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wrState_e;
  typedef enum logic       {RDIDLE, RDDATA}         rdState_e;

  wrState_e          wrState_q, wrState_d;
  rdState_e          rdState_q, rdState_d;
  logic [4:0]        wrAddr_q, wrAddr_d;
  logic [4:0]        rdAddr;
  logic [DATA_W-1:0] rdData_q, rdData_d;
  logic              apStart_q, apStart_d;
  logic              autoRestart_q, autoRestart_d;
  logic              doneLatch_q, doneLatch_d;
  logic              readyLatch_q, readyLatch_d;
  logic              gie_q, gie_d;
  logic [1:0]        ier_q, ier_d;
  logic [1:0]        isr_q, isr_d;
  logic              interrupt_q;
  logic [63:0]       args_q [NUM_ARGS];
  logic [63:0]       args_d [NUM_ARGS];
  logic              awHs, wHs, arHs;
  logic              unusedAddrBits;

  assign unusedAddrBits = ^{s_axi_control_AWADDR[ADDR_W-1:8], s_axi_control_AWADDR[2:0],
                            s_axi_control_ARADDR[ADDR_W-1:8], s_axi_control_ARADDR[2:0]};

  assign awHs   = s_axi_control_AWVALID & s_axi_control_AWREADY;
  assign wHs    = s_axi_control_WVALID  & s_axi_control_WREADY;
  assign arHs   = s_axi_control_ARVALID & s_axi_control_ARREADY;
  assign rdAddr = s_axi_control_ARADDR[7:3];

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      wrState_q <= WRIDLE;
      rdState_q <= RDIDLE;
    end else begin
      wrState_q <= wrState_d;
      rdState_q <= rdState_d;
    end
  end

  always_comb begin
    wrState_d = wrState_q;
    unique case (wrState_q)
      WRIDLE:  if (awHs) wrState_d = WRDATA;
      WRDATA:  if (wHs) wrState_d = WRRESP;
      WRRESP:  if (s_axi_control_BREADY) wrState_d = WRIDLE;
      default: wrState_d = WRIDLE;
    endcase
    rdState_d = rdState_q;
    unique case (rdState_q)
      RDIDLE:  if (arHs) rdState_d = RDDATA;
      RDDATA:  if (s_axi_control_RREADY) rdState_d = RDIDLE;
      default: rdState_d = RDIDLE;
    endcase
  end

  // Address readies are masked by reset because both FSMs reset into their idle states.
  always_comb begin
    s_axi_control_AWREADY = ap_rst_n && (wrState_q == WRIDLE);
    s_axi_control_WREADY  = (wrState_q == WRDATA);
    s_axi_control_BVALID  = (wrState_q == WRRESP);
    s_axi_control_BRESP   = 2'b00;
    s_axi_control_ARREADY = ap_rst_n && (rdState_q == RDIDLE);
    s_axi_control_RVALID  = (rdState_q == RDDATA);
    s_axi_control_RRESP   = 2'b00;
    s_axi_control_RDATA   = rdData_q;
  end

  always_comb begin
    rdData_d = '0;
    unique case (rdAddr)
      ADDR_CTRL: begin
        rdData_d[0] = apStart_q;
        rdData_d[1] = doneLatch_q;
        rdData_d[2] = ap_idle;
        rdData_d[3] = readyLatch_q;
        rdData_d[7] = autoRestart_q;
      end
      ADDR_GIE: rdData_d[0]   = gie_q;
      ADDR_IER: rdData_d[1:0] = ier_q;
      ADDR_ISR: rdData_d[1:0] = isr_q;
      default: begin
        for (int i = 0; i < NUM_ARGS; i++) begin
          if (rdAddr == ADDR_ARG0 + 5'(i)) rdData_d = args_q[i];
        end
      end
    endcase
  end

  // Register updates; set events are applied last so they win over clears and toggles.
  always_comb begin
    wrAddr_d      = awHs ? s_axi_control_AWADDR[7:3] : wrAddr_q;
    apStart_d     = apStart_q;
    autoRestart_d = autoRestart_q;
    doneLatch_d   = doneLatch_q;
    readyLatch_d  = readyLatch_q;
    gie_d         = gie_q;
    ier_d         = ier_q;
    isr_d         = isr_q;
    args_d        = args_q;
    if (ap_ready && !autoRestart_q) apStart_d = 1'b0;
    if (wHs && s_axi_control_WSTRB[0]) begin
      unique case (wrAddr_q)
        ADDR_CTRL: begin
          if (s_axi_control_WDATA[0]) apStart_d = 1'b1;
          autoRestart_d = s_axi_control_WDATA[7];
        end
        ADDR_GIE: gie_d = s_axi_control_WDATA[0];
        ADDR_IER: ier_d = s_axi_control_WDATA[1:0];
        ADDR_ISR: isr_d = isr_q ^ s_axi_control_WDATA[1:0];
        default: ;
      endcase
    end
    for (int i = 0; i < NUM_ARGS; i++) begin
      if (wHs && (wrAddr_q == ADDR_ARG0 + 5'(i))) begin
        for (int k = 0; k < 8; k++) begin
          if (s_axi_control_WSTRB[k]) args_d[i][8*k +: 8] = s_axi_control_WDATA[8*k +: 8];
        end
      end
    end
    if (arHs && (rdAddr == ADDR_CTRL)) begin
      doneLatch_d  = 1'b0;
      readyLatch_d = 1'b0;
    end
    if (ap_done)  doneLatch_d  = 1'b1;
    if (ap_ready) readyLatch_d = 1'b1;
    if (ap_done  && ier_q[0]) isr_d[0] = 1'b1;
    if (ap_ready && ier_q[1]) isr_d[1] = 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      wrAddr_q      <= '0;
      rdData_q      <= '0;
      apStart_q     <= 1'b0;
      autoRestart_q <= 1'b0;
      doneLatch_q   <= 1'b0;
      readyLatch_q  <= 1'b0;
      gie_q         <= 1'b0;
      ier_q         <= '0;
      isr_q         <= '0;
      interrupt_q   <= 1'b0;
      args_q        <= '{default: '0};
    end else begin
      wrAddr_q      <= wrAddr_d;
      if (arHs) rdData_q <= rdData_d;
      apStart_q     <= apStart_d;
      autoRestart_q <= autoRestart_d;
      doneLatch_q   <= doneLatch_d;
      readyLatch_q  <= readyLatch_d;
      gie_q         <= gie_d;
      ier_q         <= ier_d;
      isr_q         <= isr_d;
      interrupt_q   <= gie_q & (|isr_q);
      args_q        <= args_d;
    end
  end

  always_comb begin
    args = '0;
    for (int i = 0; i < NUM_ARGS; i++) args[64*i +: 64] = args_q[i];
  end

  assign ap_start  = apStart_q;
  assign interrupt = interrupt_q;

endmodule

// File: tb/tb_axil_ctrl_slave.sv
// Scoreboard bench for axil_ctrl_slave: bus tasks queue the expected B/R responses and a
// negedge monitor pops and compares them; kernel-side effects are checked directly.
module tb_axil_ctrl_slave;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          AWVALID = 1'b0, AWREADY;
  logic [31:0]   AWADDR = '0;
  logic          WVALID = 1'b0, WREADY;
  logic [63:0]   WDATA = '0;
  logic [7:0]    WSTRB = '0;
  logic          BVALID, BREADY = 1'b1;
  logic [1:0]    BRESP;
  logic          ARVALID = 1'b0, ARREADY;
  logic [31:0]   ARADDR = '0;
  logic          RVALID, RREADY = 1'b1;
  logic [63:0]   RDATA;
  logic [1:0]    RRESP;
  logic          ap_start, ap_done = 1'b0, ap_idle = 1'b1, ap_ready = 1'b0;
  logic [255:0]  args;
  logic          interrupt;

  int            testsRun = 0;
  int            failures = 0;
  logic [1:0]    expB[$];
  logic [63:0]   expR[$];
  bit            stallB = 0, stallR = 0;
  logic [63:0]   prevRdata;

  axil_ctrl_slave #(.ADDR_W(32), .DATA_W(64), .NUM_ARGS(4)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axi_control_AWVALID(AWVALID), .s_axi_control_AWREADY(AWREADY), .s_axi_control_AWADDR(AWADDR),
    .s_axi_control_WVALID(WVALID), .s_axi_control_WREADY(WREADY), .s_axi_control_WDATA(WDATA),
    .s_axi_control_WSTRB(WSTRB), .s_axi_control_BVALID(BVALID), .s_axi_control_BREADY(BREADY),
    .s_axi_control_BRESP(BRESP), .s_axi_control_ARVALID(ARVALID), .s_axi_control_ARREADY(ARREADY),
    .s_axi_control_ARADDR(ARADDR), .s_axi_control_RVALID(RVALID), .s_axi_control_RREADY(RREADY),
    .s_axi_control_RDATA(RDATA), .s_axi_control_RRESP(RRESP),
    .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .args(args), .interrupt(interrupt)
  );

  // 100 MHz clock; inputs change 1 ns after the rising edge, checks happen on the falling edge.
  always #5 ap_clk = ~ap_clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Wait (bounded) until the selected handshake signal is seen high, then step past the edge.
  task automatic waitHigh(input int which, input string name);
    bit seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge ap_clk);
      case (which)
        0: seen = AWREADY;
        1: seen = WREADY;
        2: seen = BVALID;
        3: seen = ARREADY;
        default: seen = RVALID;
      endcase
    end
    if (!seen) begin
      testsRun++;
      failures++;
      $display("[TB] FAIL timeout %s: got 0, expected 1", name);
    end
    tick();
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input bit expectB);
    if (expectB) expB.push_back(2'b00);
    AWADDR = addr;
    AWVALID = 1'b1;
    waitHigh(0, "awready");
    AWVALID = 1'b0;
    WDATA = data;
    WSTRB = strb;
    WVALID = 1'b1;
    waitHigh(1, "wready");
    WVALID = 1'b0;
    waitHigh(2, "bvalid");
  endtask

  task automatic readReg(input logic [31:0] addr, input logic [63:0] expected);
    expR.push_back(expected);
    ARADDR = addr;
    ARVALID = 1'b1;
    waitHigh(3, "arready");
    ARVALID = 1'b0;
    waitHigh(4, "rvalid");
  endtask

  // Kernel-side one-cycle pulses: 0 = ap_done, 1 = ap_ready.
  task automatic applyStimulus(input int which);
    if (which == 0) ap_done = 1'b1;
    else ap_ready = 1'b1;
    tick();
    ap_done = 1'b0;
    ap_ready = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every completed B/R handshake and checks stalled responses hold.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      stallB = 0;
      stallR = 0;
    end else begin
      if (stallR) begin
        checkOutput("rvalidHeld", {63'b0, RVALID}, 64'd1);
        checkOutput("rdataHeld", RDATA, prevRdata);
      end
      if (stallB) checkOutput("bvalidHeld", {63'b0, BVALID}, 64'd1);
      if (RVALID && RREADY) begin
        if (expR.size() == 0) begin
          testsRun++;
          failures++;
          $display("[TB] FAIL rUnexpected: got 0x%0h, expected no response", RDATA);
        end else begin
          checkOutput("rdata", RDATA, expR.pop_front());
          checkOutput("rresp", {62'b0, RRESP}, 64'd0);
        end
      end
      if (BVALID && BREADY) begin
        if (expB.size() == 0) begin
          testsRun++;
          failures++;
          $display("[TB] FAIL bUnexpected: got 0x%0h, expected no response", BRESP);
        end else begin
          checkOutput("bresp", {62'b0, BRESP}, {62'b0, expB.pop_front()});
        end
      end
      stallR = RVALID && !RREADY;
      stallB = BVALID && !BREADY;
      prevRdata = RDATA;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) tick();
    @(negedge ap_clk);
    checkOutput("rstAwready", {63'b0, AWREADY}, 64'd0);
    checkOutput("rstArready", {63'b0, ARREADY}, 64'd0);
    checkOutput("rstValids", {62'b0, BVALID, RVALID}, 64'd0);
    checkOutput("rstStart", {63'b0, ap_start}, 64'd0);
    checkOutput("rstIrq", {63'b0, interrupt}, 64'd0);
    checkOutput("rstArgs", {63'b0, |args}, 64'd0);
    tick();
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    checkOutput("relAwready", {63'b0, AWREADY}, 64'd1);
    checkOutput("relArready", {63'b0, ARREADY}, 64'd1);
    tick();

    // Argument register with partial byte strobe
    writeReg(32'h28, 64'h1122334455667788, 8'hFF, 1);
    writeReg(32'h28, 64'h00000000000000AA, 8'h01, 1);
    readReg(32'h28, 64'h11223344556677AA);
    checkOutput("args1", args[127:64], 64'h11223344556677AA);
    readReg(32'h40, 64'h0);

    // ap_start handshake and auto-restart
    writeReg(32'h00, 64'h1, 8'h01, 1);
    checkOutput("startSet", {63'b0, ap_start}, 64'd1);
    applyStimulus(1);
    @(negedge ap_clk);
    checkOutput("startClr", {63'b0, ap_start}, 64'd0);
    tick();
    writeReg(32'h00, 64'h81, 8'h01, 1);
    applyStimulus(1);
    @(negedge ap_clk);
    checkOutput("startAuto", {63'b0, ap_start}, 64'd1);
    tick();
    writeReg(32'h00, 64'h0, 8'h01, 1);
    checkOutput("startWr0", {63'b0, ap_start}, 64'd1);
    applyStimulus(1);
    @(negedge ap_clk);
    checkOutput("startClr2", {63'b0, ap_start}, 64'd0);
    tick();
    readReg(32'h00, 64'h0C);
    readReg(32'h00, 64'h04);

    // done latch: clear-on-read, and ap_done coincident with the read wins
    applyStimulus(0);
    readReg(32'h00, 64'h06);
    readReg(32'h00, 64'h04);
    fork
      readReg(32'h00, 64'h04);
      applyStimulus(0);
    join
    readReg(32'h00, 64'h06);
    readReg(32'h00, 64'h04);

    // Interrupt path and toggle-on-write ISR
    writeReg(32'h08, 64'h1, 8'h01, 1);
    writeReg(32'h10, 64'h1, 8'h01, 1);
    applyStimulus(0);
    @(negedge ap_clk);
    checkOutput("irqLag", {63'b0, interrupt}, 64'd0);
    @(negedge ap_clk);
    checkOutput("irqSet", {63'b0, interrupt}, 64'd1);
    tick();
    readReg(32'h18, 64'h1);
    writeReg(32'h18, 64'h1, 8'h01, 1);
    @(negedge ap_clk);
    checkOutput("irqClr", {63'b0, interrupt}, 64'd0);
    tick();
    readReg(32'h18, 64'h0);
    writeReg(32'h18, 64'h2, 8'h01, 1);
    readReg(32'h18, 64'h2);
    checkOutput("irqToggle", {63'b0, interrupt}, 64'd1);
    writeReg(32'h18, 64'h2, 8'h01, 1);
    readReg(32'h18, 64'h0);

    // W before AW, AW+AR in the same cycle, responses stalled for five cycles
    BREADY = 1'b0;
    RREADY = 1'b0;
    WDATA = 64'hDEADBEEFCAFEF00D;
    WSTRB = 8'hFF;
    WVALID = 1'b1;
    @(negedge ap_clk);
    checkOutput("wreadyHeldOff", {63'b0, WREADY}, 64'd0);
    tick();
    expB.push_back(2'b00);
    expR.push_back(64'h0);
    AWADDR = 32'h20;
    ARADDR = 32'h20;
    AWVALID = 1'b1;
    ARVALID = 1'b1;
    @(negedge ap_clk);
    checkOutput("awArReady", {62'b0, AWREADY, ARREADY}, 64'd3);
    tick();
    AWVALID = 1'b0;
    ARVALID = 1'b0;
    @(negedge ap_clk);
    checkOutput("wreadyOpen", {63'b0, WREADY}, 64'd1);
    tick();
    WVALID = 1'b0;
    repeat (5) tick();
    BREADY = 1'b1;
    RREADY = 1'b1;
    tick();
    tick();
    readReg(32'h20, 64'hDEADBEEFCAFEF00D);
    checkOutput("args0", args[63:0], 64'hDEADBEEFCAFEF00D);

    // Reset while a write response is pending
    writeReg(32'h30, 64'h0123456789ABCDEF, 8'hFF, 1);
    writeReg(32'h00, 64'h1, 8'h01, 1);
    checkOutput("startPreRst", {63'b0, ap_start}, 64'd1);
    BREADY = 1'b0;
    writeReg(32'h30, 64'h5555, 8'hFF, 0);
    @(negedge ap_clk);
    checkOutput("bvalidPending", {63'b0, BVALID}, 64'd1);
    tick();
    ap_rst_n = 1'b0;
    tick();
    @(negedge ap_clk);
    checkOutput("rstBvalid", {63'b0, BVALID}, 64'd0);
    checkOutput("rstStart2", {63'b0, ap_start}, 64'd0);
    checkOutput("rstArgs2", {63'b0, |args}, 64'd0);
    tick();
    ap_rst_n = 1'b1;
    BREADY = 1'b1;
    tick();
    readReg(32'h30, 64'h0);
    repeat (3) tick();

    checkOutput("bQueueEmpty", 64'(expB.size()), 64'd0);
    checkOutput("rQueueEmpty", 64'(expR.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
